dmem_access_ctrl: RTL and testbench



---
 rtl/y86_pkg.sv | 28 ++
 rtl/dmem_decode.sv | 40 ++++
 rtl/dmem_access_ctrl.sv | 138 +++++++++++++
 tb/tb_dmem_access_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, memory-controller FSM states,
// and the status codes write-back uses to report the memory-stage outcome.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SADR = 3'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } dmem_state_t;

endpackage

// File: rtl/dmem_decode.sv
// Memory-stage decode: icode selects read/write, address source and store data.
// Purely combinational; shared with the hazard unit, so it carries no state.
module dmem_decode
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [3:0]   icode_i,
    input  logic [W-1:0] valA_i,
    input  logic [W-1:0] valE_i,
    input  logic [W-1:0] valP_i,
    output logic         rd_o,
    output logic         wr_o,
    output logic [W-1:0] addr_o,
    output logic [W-1:0] wdata_o
);

    always_comb begin
        rd_o    = 1'b0;
        wr_o    = 1'b0;
        addr_o  = valE_i;
        wdata_o = valA_i;
        case (icode_i)
            IRMMOVQ: wr_o = 1'b1;
            IMRMOVQ: rd_o = 1'b1;
            ICALL: begin
                wr_o    = 1'b1;
                wdata_o = valP_i;
            end
            IPUSHQ:  wr_o = 1'b1;
            // ret and popq read through the stack pointer, not the ALU result
            IRET, IPOPQ: begin
                rd_o   = 1'b1;
                addr_o = valA_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Y86-64 data-memory initiator: one op per transaction over req/gnt/rvalid.
// Latency: 2 cycles for non-memory icodes, 3+ for accesses (accept, req, resp).
// Backpressure: holds the result until out_ready; in_ready only while idle.
module dmem_access_ctrl
    import y86_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MEM_BYTES = 8192,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [ADDR_W-1:0] valA,
    input  logic [ADDR_W-1:0] valE,
    input  logic [ADDR_W-1:0] valP,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_icode,
    output logic [DATA_W-1:0] valM,
    output logic              dmem_error,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_err
);

    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 8);

    dmem_state_t       state_q;
    logic              in_ready_q, out_valid_q, err_q, rd_q;
    logic              mem_req_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q, valm_q;
    logic [3:0]        out_icode_q;
    logic [7:0]        cnt_q, cnt_d;

    logic              dec_rd, dec_wr;
    logic [ADDR_W-1:0] dec_addr, dec_wdata;
    logic              range_err;

    dmem_decode #(.W(ADDR_W)) u_decode (
        .icode_i (icode),
        .valA_i  (valA),
        .valE_i  (valE),
        .valP_i  (valP),
        .rd_o    (dec_rd),
        .wr_o    (dec_wr),
        .addr_o  (dec_addr),
        .wdata_o (dec_wdata)
    );

    // Unsigned compare, so wrapped "negative" addresses are rejected too
    assign range_err = dec_addr > MAX_ADDR;
    assign cnt_d     = cnt_q + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_icode_q <= '0;
            valm_q      <= '0;
            err_q       <= 1'b0;
            rd_q        <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    in_ready_q  <= 1'b0;
                    out_icode_q <= icode;
                    rd_q        <= dec_rd;
                    mem_we_q    <= dec_wr;
                    mem_addr_q  <= dec_addr;
                    mem_wdata_q <= DATA_W'(dec_wdata);
                    valm_q      <= '0;
                    cnt_q       <= '0;
                    if (!(dec_rd || dec_wr) || range_err) begin
                        state_q     <= S_RESP;
                        out_valid_q <= 1'b1;
                        err_q       <= (dec_rd || dec_wr) && range_err;
                    end else begin
                        state_q   <= S_REQ;
                        mem_req_q <= 1'b1;
                        err_q     <= 1'b0;
                    end
                end
                S_REQ, S_WAIT: begin
                    cnt_q <= cnt_d;
                    // rvalid only counts once the request has been granted
                    if (mem_rvalid && (state_q == S_WAIT || mem_gnt)) begin
                        state_q     <= S_RESP;
                        mem_req_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        valm_q      <= rd_q ? mem_rdata : '0;
                        err_q       <= mem_err;
                    end else if (cnt_d == 8'(TIMEOUT)) begin
                        state_q     <= S_RESP;
                        mem_req_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        valm_q      <= '0;
                        err_q       <= 1'b1;
                    end else if (state_q == S_REQ && mem_gnt) begin
                        state_q   <= S_WAIT;
                        mem_req_q <= 1'b0;
                    end
                end
                S_RESP: if (out_ready) begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_icode  = out_icode_q;
    assign valM       = valm_q;
    assign dmem_error = err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: vector table plus timeout, reset and stall
// sequences against a negedge-driven memory model with programmable latency.
module tb_dmem_access_ctrl;

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [3:0]  icode;
    logic [63:0] valA, valE, valP;
    logic        out_valid, out_ready;
    logic [3:0]  out_icode;
    logic [63:0] valM;
    logic        dmem_error;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic        mem_gnt, mem_rvalid, mem_err;
    logic [63:0] mem_rdata;

    dmem_access_ctrl #(
        .ADDR_W(64), .DATA_W(64), .MEM_BYTES(8192), .TIMEOUT(255)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .icode(icode), .valA(valA), .valE(valE), .valP(valP),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_icode(out_icode), .valM(valM), .dmem_error(dmem_error),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model configuration, written by the main sequence
    int   lat_cfg;
    logic silent, err_inj, stray_req;

    logic [63:0] mem_arr [1024];
    int          pend;
    int          idx;
    logic [63:0] pend_data;

    initial begin
        for (int i = 0; i < 1024; i++) mem_arr[i] = '0;
        pend = 0;
        pend_data = '0;
        idx = 0;
    end

    always @(negedge clk) begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_err    = 1'b0;
        mem_rdata  = '0;
        if (stray_req) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 64'h0000_0000_0000_BAD0;
        end else if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend_data;
                mem_err    = err_inj;
            end
        end else if (mem_req) begin
            mem_gnt = 1'b1;
            if (!silent) begin
                idx       = int'(mem_addr[12:3]);
                pend_data = mem_we ? 64'h0 : mem_arr[idx];
                if (mem_we) mem_arr[idx] = mem_wdata;
                if (lat_cfg == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = pend_data;
                    mem_err    = err_inj;
                end else begin
                    pend = lat_cfg;
                end
            end
        end
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  icode;
        logic [63:0] val_a, val_e, val_p;
        int          lat;
        logic        err_inj;
        logic        exp_req, exp_we;
        logic [63:0] exp_addr, exp_wdata, exp_valm;
        logic        exp_err;
        int          exp_cyc;   // clock edges from accept to out_valid
    } vec_t;

    vec_t vecs[13];

    task automatic run_vec(input int k, input vec_t v);
        int          n;
        logic        seen_req, ready_bad, s_we;
        logic [63:0] s_addr, s_wdata;
        string       tag;
        tag = $sformatf("v%0d", k);
        @(negedge clk);
        chk({tag, "_in_ready_idle"}, in_ready, 1);
        lat_cfg  = v.lat;
        err_inj  = v.err_inj;
        in_valid = 1'b1;
        icode    = v.icode;
        valA     = v.val_a;
        valE     = v.val_e;
        valP     = v.val_p;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        icode = 4'h0; valA = '0; valE = '0; valP = '0;
        n = 0; seen_req = 0; ready_bad = 0;
        s_we = 0; s_addr = '0; s_wdata = '0;
        while (!out_valid && n < 400) begin
            if (mem_req && !seen_req) begin
                seen_req = 1'b1;
                s_we     = mem_we;
                s_addr   = mem_addr;
                s_wdata  = mem_wdata;
            end
            if (in_ready) ready_bad = 1'b1;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (in_ready) ready_bad = 1'b1;
        chk({tag, "_latency"}, 64'(n), 64'(v.exp_cyc));
        chk({tag, "_req_seen"}, seen_req, v.exp_req);
        if (v.exp_req) begin
            chk({tag, "_we"}, s_we, v.exp_we);
            chk({tag, "_addr"}, s_addr, v.exp_addr);
            if (v.exp_we) chk({tag, "_wdata"}, s_wdata, v.exp_wdata);
        end
        chk({tag, "_in_ready_busy"}, ready_bad, 0);
        chk({tag, "_out_icode"}, out_icode, v.icode);
        chk({tag, "_valM"}, valM, v.exp_valm);
        chk({tag, "_err"}, dmem_error, v.exp_err);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_out_valid_drop"}, out_valid, 0);
        chk({tag, "_in_ready_back"}, in_ready, 1);
    endtask

    initial begin
        int   n;
        logic bad;
        logic [63:0] hold_valm;

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        icode = 4'h0; valA = '0; valE = '0; valP = '0;
        lat_cfg = 0; silent = 1'b0; err_inj = 1'b0; stray_req = 1'b0;

        //            icode  valA                   valE                   valP      lat err  req we  addr      wdata                  valM                   err cyc
        vecs[0]  = '{4'h4, 64'h1122334455667788, 64'h100,               64'h0,    0,  0,  1,  1,  64'h100,  64'h1122334455667788, 64'h0,                 0,  1};
        vecs[1]  = '{4'h5, 64'h0,                64'h100,               64'h0,    3,  0,  1,  0,  64'h100,  64'h0,                 64'h1122334455667788, 0,  4};
        vecs[2]  = '{4'h8, 64'h5,                64'h1F8,               64'h40,   0,  0,  1,  1,  64'h1F8,  64'h40,                64'h0,                 0,  1};
        vecs[3]  = '{4'h9, 64'h1F8,              64'h0,                 64'h0,    1,  0,  1,  0,  64'h1F8,  64'h0,                 64'h40,                0,  2};
        vecs[4]  = '{4'h1, 64'h1F8,              64'h100,               64'h0,    0,  0,  0,  0,  64'h0,    64'h0,                 64'h0,                 0,  0};
        vecs[5]  = '{4'h5, 64'h0,                64'h2000,              64'h0,    0,  0,  0,  0,  64'h0,    64'h0,                 64'h0,                 1,  0};
        vecs[6]  = '{4'hA, 64'hCAFE,             64'h1FF8,              64'h0,    2,  0,  1,  1,  64'h1FF8, 64'hCAFE,              64'h0,                 0,  3};
        vecs[7]  = '{4'hB, 64'h1FF8,             64'h0,                 64'h0,    0,  0,  1,  0,  64'h1FF8, 64'h0,                 64'hCAFE,              0,  1};
        vecs[8]  = '{4'h5, 64'h0,                64'h1FF9,              64'h0,    0,  0,  0,  0,  64'h0,    64'h0,                 64'h0,                 1,  0};
        vecs[9]  = '{4'h4, 64'h77,               64'hFFFFFFFFFFFFFFF8,  64'h0,    0,  0,  0,  0,  64'h0,    64'h0,                 64'h0,                 1,  0};
        vecs[10] = '{4'h5, 64'h0,                64'h100,               64'h0,    1,  1,  1,  0,  64'h100,  64'h0,                 64'h1122334455667788, 1,  2};
        vecs[11] = '{4'h0, 64'h0,                64'h0,                 64'h0,    0,  0,  0,  0,  64'h0,    64'h0,                 64'h0,                 0,  0};
        vecs[12] = '{4'h3, 64'h0,                64'h2000,              64'h0,    0,  0,  0,  0,  64'h0,    64'h0,                 64'h0,                 0,  0};

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_valM", valM, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        for (int k = 0; k < 13; k++) run_vec(k, vecs[k]);

        // popq against a memory that grants but never responds
        silent = 1'b1;
        run_vec(13, '{4'hB, 64'h100, 64'h0, 64'h0, 0, 0, 1, 0, 64'h100, 64'h0, 64'h0, 1, 255});
        silent = 1'b0;
        @(posedge clk);
        #2 stray_req = 1'b1;
        @(posedge clk);
        #2 stray_req = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid || !in_ready) bad = 1'b1;
        end
        chk("stray_rvalid_ignored", bad, 0);

        // reset while waiting on a slow read
        lat_cfg = 5;
        @(negedge clk);
        in_valid = 1'b1; icode = 4'h5; valE = 64'h100;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; icode = 4'h0; valE = '0;
        @(posedge clk);
        @(negedge clk);
        chk("wait_mem_req_low", mem_req, 0);
        rst_n = 1'b0;
        #1;
        chk("arst_mem_req", mem_req, 0);
        chk("arst_mem_we", mem_we, 0);
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_mem_wdata", mem_wdata, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_icode", out_icode, 0);
        chk("arst_valM", valM, 0);
        chk("arst_err", dmem_error, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid || mem_req || !in_ready) bad = 1'b1;
        end
        chk("post_rst_quiet", bad, 0);

        // result held stable while write-back stalls
        lat_cfg = 0;
        @(negedge clk);
        in_valid = 1'b1; icode = 4'h5; valE = 64'h100;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; icode = 4'h0; valE = '0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("stall_latency", 64'(n), 1);
        hold_valm = 64'h1122334455667788;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (!out_valid || valM !== hold_valm || dmem_error || out_icode !== 4'h5 || in_ready)
                bad = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        chk("stall_stable", bad, 0);
        chk("stall_valM", valM, hold_valm);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("stall_release", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
